// File: rtl/ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_reader
// Description : Sweeps a RAM address range once per i_start, issuing one read
//               per cycle, and presents each returned 64-bit word registered.
//               Optional pattern checker (word k at address A = 4A+k) is
//               compiled in with macro RAMREADER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_reader #(
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [13:0] START_ADDR = 14'd1,
  parameter logic [13:0] END_ADDR   = 14'd8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_data,
  output logic [13:0] o_address,
  output logic        o_rden,
  output logic [63:0] o_word,
  output logic        o_word_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [13:0] o_err_count,
  output logic [13:0] o_first_err_addr
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // DRAIN lasts RD_LATENCY+1 cycles so the last word is on o_word before DONE
  localparam logic [2:0] c_drain_last = 3'(RD_LATENCY);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [13:0] r_address;
  logic        r_rden;
  logic [2:0]  r_drain_cnt;
  logic        r_pipe_vld [RD_LATENCY];
  logic        w_tail_vld;
  logic [63:0] r_word;
  logic        r_word_valid;

  assign w_tail_vld   = r_pipe_vld[RD_LATENCY-1];
  assign o_address    = r_address;
  assign o_rden       = r_rden;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  // Next-state logic; DONE always returns to IDLE so a start there is dropped
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (i_start) w_state_next = c_st_issue;
      c_st_issue: if (r_address == END_ADDR) w_state_next = c_st_drain;
      c_st_drain: if (r_drain_cnt == c_drain_last) w_state_next = c_st_done;
      c_st_done:  w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_busy = (r_state != c_st_idle);
    o_done = (r_state == c_st_done);
  end

  // Read address / enable generation; address stops at END_ADDR (no wrap)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_address <= '0;
      r_rden    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_address <= START_ADDR;
            r_rden    <= 1'b1;
          end
        end
        c_st_issue: begin
          if (r_address == END_ADDR) r_rden    <= 1'b0;
          else                       r_address <= r_address + 14'd1;
        end
        default: r_rden <= 1'b0;
      endcase
    end
  end

  // Drain cycle counter, only runs in DRAIN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_drain_cnt <= '0;
    else if (r_state == c_st_drain) r_drain_cnt <= r_drain_cnt + 3'd1;
    else                            r_drain_cnt <= '0;
  end

  // Valid lane of the read pipeline: tail marks the cycle i_data is good
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) r_pipe_vld[i] <= 1'b0;
    end else begin
      r_pipe_vld[0] <= r_rden;
      for (int i = 1; i < int'(RD_LATENCY); i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  // Capture returned data into the registered word output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_tail_vld;
      if (w_tail_vld) r_word <= i_data;
    end
  end

`ifdef RAMREADER_CHECK_EN
  // Address lane of the read pipeline; only the checker consumes it
  logic [13:0] r_pipe_addr [RD_LATENCY];
  logic [13:0] w_tail_addr;
  logic [63:0] w_expected;
  logic        w_mismatch;
  logic [13:0] r_err_count;
  logic [13:0] r_first_err_addr;

  assign w_tail_addr = r_pipe_addr[RD_LATENCY-1];

  // Shift the address alongside its valid bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) r_pipe_addr[i] <= '0;
    end else begin
      r_pipe_addr[0] <= r_address;
      for (int i = 1; i < int'(RD_LATENCY); i++) r_pipe_addr[i] <= r_pipe_addr[i-1];
    end
  end

  // Expected pattern: 4A+k is just A with k appended in the two LSBs
  always_comb begin
    w_expected = {w_tail_addr, 2'b11, w_tail_addr, 2'b10,
                  w_tail_addr, 2'b01, w_tail_addr, 2'b00};
    w_mismatch = w_tail_vld && (i_data != w_expected);
  end

  // Saturating error count and first-error address, updated with o_word_valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (r_state == c_st_idle && i_start) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (w_mismatch) begin
      if (r_err_count != 14'h3FFF) r_err_count <= r_err_count + 14'd1;
      if (r_err_count == 14'd0)    r_first_err_addr <= w_tail_addr;
    end
  end

  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
`else
  assign o_err_count      = '0;
  assign o_first_err_addr = '0;
`endif

endmodule
`default_nettype wire

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2, cycles from o_rden high to valid i_data, legal 1..4.
REQ-002 SHALL have parameter START_ADDR, default 14'd1, first address read.
REQ-003 SHALL have parameter END_ADDR, default 14'd8192, last address read, inclusive, END_ADDR >= START_ADDR.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_start, input, 1, one-cycle pulse that begins a sweep.
REQ-007 SHALL have port i_data, input, 64, RAM read data {word4,word3,word2,word1}, 16 bits each.
REQ-008 SHALL have port o_address, output, 14, RAM read address.
REQ-009 SHALL have port o_rden, output, 1, RAM read enable, one read per high cycle.
REQ-010 SHALL have port o_word, output, 64, captured read data.
REQ-011 SHALL have port o_word_valid, output, 1, o_word valid this cycle.
REQ-012 SHALL have port o_busy, output, 1, sweep in progress.
REQ-013 SHALL have port o_done, output, 1, one-cycle pulse at sweep end.
REQ-014 SHALL have port o_err_count, output, 14, number of mismatching words this sweep.
REQ-015 SHALL have port o_first_err_addr, output, 14, address of first mismatch this sweep.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: i_start=1 -> ISSUE next cycle; clear o_err_count, o_first_err_addr; o_address <= START_ADDR.
REQ-018 ISSUE: o_rden=1 every cycle; o_address increments by 1 per cycle; o_rden and o_address are registered.
REQ-019 ISSUE -> DRAIN on the cycle the read of END_ADDR is issued; no address beyond END_ADDR is driven with o_rden=1.
REQ-020 DRAIN: o_rden=0; stays until the last issued read returns, i.e. RD_LATENCY cycles, then DONE.
REQ-021 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-022 o_busy SHALL be 1 in ISSUE, DRAIN and DONE, 0 in IDLE.
REQ-023 A RD_LATENCY-deep shift register SHALL carry {valid, address} alongside each read; i_data is sampled when its tail is valid.
REQ-024 o_word/o_word_valid SHALL be registered: o_word_valid rises RD_LATENCY+1 cycles after the matching o_rden.
REQ-025 Exactly END_ADDR-START_ADDR+1 o_word_valid pulses SHALL occur per sweep, in ascending address order.
REQ-026 i_start while o_busy=1 SHALL be ignored.
REQ-027 i_start in the DONE cycle SHALL be ignored; a new sweep needs i_start in IDLE.
REQ-028 Address arithmetic SHALL be 14-bit; END_ADDR=16383 SHALL end the sweep without wrapping to 0.

Reset
REQ-029 i_rst=1 SHALL asynchronously force IDLE, o_address=0, o_rden=0, o_word=0, o_word_valid=0, o_busy=0, o_done=0, o_err_count=0, o_first_err_addr=0, pipeline valids=0.
REQ-030 Reset mid-sweep SHALL abort; in-flight reads are discarded, no o_word_valid or o_done follows.
REQ-031 After reset deassertion the block SHALL idle until i_start.

Configuration
REQ-032 Macro RAMREADER_CHECK_EN SHALL compile in the pattern checker.
REQ-033 With RAMREADER_CHECK_EN: word at address A SHALL match word1=4A, word2=4A+1, word3=4A+2, word4=4A+3, each modulo 2^16.
REQ-034 With RAMREADER_CHECK_EN: each mismatch increments o_err_count, saturating at 16383; the first mismatch latches o_first_err_addr; both update with o_word_valid.
REQ-035 Without RAMREADER_CHECK_EN: o_err_count and o_first_err_addr SHALL be constant 0; all other behaviour identical.

Verification
REQ-036 RAM model latency 2, preloaded with the pattern for 1..8192, i_start -> 8192 o_word_valid pulses, o_done after, o_err_count=0.
REQ-037 Same with address 100 word2 corrupted to 16'h0000 -> o_err_count=1, o_first_err_addr=100; o_err_count=0 without RAMREADER_CHECK_EN.
REQ-038 START_ADDR=END_ADDR=5, RD_LATENCY=4 -> one o_rden cycle, o_word_valid 5 cycles later, o_done next cycle.
REQ-039 i_rst pulsed when o_address=300 -> outputs at reset values same cycle, no o_done, next i_start restarts at address 1.
REQ-040 i_start pulsed in ISSUE and in DONE -> ignored; o_word_valid count stays 8192; single o_done.
